// File: rtl/lsu_pkg.sv
// Shared types and memory-opcode bit positions for the load/store unit.
// Supplies XLEN/MEM_OP_WIDTH defaults when core.svh has not already defined them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_OP_WIDTH
`define MEM_OP_WIDTH 4
`endif

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Bit positions inside the decoder's one-hot mem_opcode.
  localparam int MEM_OP_BYTE   = 0;
  localparam int MEM_OP_HALF   = 1;
  localparam int MEM_OP_WORD   = 2;
  localparam int MEM_OP_UNSIGN = 3;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replicated data and load shift/extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [`MEM_OP_WIDTH-1:0] opcode,
  input  logic [1:0]               offset,
  input  logic [DW-1:0]            wdata,
  input  logic [DW-1:0]            rdata,
  output logic [3:0]               wstrb,
  output logic [DW-1:0]            wdata_lane,
  output logic [DW-1:0]            rdata_ext
);

  logic [DW-1:0] shifted;
  logic          sext;

  // Lanes that fall past byte 3 are simply truncated away.
  always_comb begin
    shifted    = rdata >> {offset, 3'b000};
    sext       = ~opcode[MEM_OP_UNSIGN];
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = shifted;
    if (opcode[MEM_OP_BYTE]) begin
      wstrb      = 4'b0001 << offset;
      wdata_lane = {4{wdata[7:0]}};
      rdata_ext  = {{24{sext & shifted[7]}}, shifted[7:0]};
    end else if (opcode[MEM_OP_HALF]) begin
      wstrb      = 4'b0011 << offset;
      wdata_lane = {2{wdata[15:0]}};
      rdata_ext  = {{16{sext & shifted[15]}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one word-aligned bus transaction at a time with byte strobes.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned HALF/WORD accesses with resp_err.
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = `XLEN,
  parameter int DW = `XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_read,
  input  logic                     req_write,
  input  logic [`MEM_OP_WIDTH-1:0] req_opcode,
  input  logic [AW-1:0]            req_addr,
  input  logic [DW-1:0]            req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DW-1:0]            resp_rdata,
  output logic                     resp_err,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [AW-1:0]            bus_addr,
  output logic [3:0]               bus_wstrb,
  output logic [DW-1:0]            bus_wdata,
  input  logic                     bus_gnt,
  input  logic                     bus_rvalid,
  input  logic [DW-1:0]            bus_rdata
);

  lsu_state_t                 state, state_next;
  logic                       accept;
  logic                       misalign;
  logic [3:0]                 wstrb_q;
  logic [`MEM_OP_WIDTH-1:0]   op_q;
  logic [1:0]                 off_q;
  logic [3:0]                 st_wstrb;
  logic [DW-1:0]              st_wdata;
  logic [DW-1:0]              ld_data;
  logic [DW-1:0]              st_unused_rdata;
  logic [3:0]                 ld_unused_wstrb;
  logic [DW-1:0]              ld_unused_wdata;

  assign accept = (state == IDLE) & req_valid & (req_read | req_write);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (req_opcode[MEM_OP_HALF] & req_addr[0]) |
                    (req_opcode[MEM_OP_WORD] & (|req_addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  lsu_align #(.DW(DW)) u_store_align (
    .opcode     (req_opcode),
    .offset     (req_addr[1:0]),
    .wdata      (req_wdata),
    .rdata      ('0),
    .wstrb      (st_wstrb),
    .wdata_lane (st_wdata),
    .rdata_ext  (st_unused_rdata)
  );

  lsu_align #(.DW(DW)) u_load_align (
    .opcode     (op_q),
    .offset     (off_q),
    .wdata      ('0),
    .rdata      (bus_rdata),
    .wstrb      (ld_unused_wstrb),
    .wdata_lane (ld_unused_wdata),
    .rdata_ext  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = misalign ? RESP : REQ;
      REQ:  if (bus_gnt) state_next = bus_we ? RESP : WAIT;
      WAIT: if (bus_rvalid) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) & ~rst;
    bus_req    = (state == REQ);
    resp_valid = (state == RESP);
    bus_wstrb  = (state == REQ) ? wstrb_q : 4'b0000;
  end

  // Bus fields are frozen at accept; resp_rdata only moves on accept or load return.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      wstrb_q    <= 4'b0000;
      bus_wdata  <= '0;
      op_q       <= '0;
      off_q      <= 2'b00;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      bus_we     <= req_write;
      bus_addr   <= {req_addr[AW-1:2], 2'b00};
      wstrb_q    <= st_wstrb;
      bus_wdata  <= st_wdata;
      op_q       <= req_opcode;
      off_q      <= req_addr[1:0];
      resp_rdata <= '0;
      resp_err   <= misalign;
    end else if ((state == WAIT) && bus_rvalid) begin
      resp_rdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed, table-driven bench for lsu plus hand-written multi-cycle sequences.
module tb_lsu;
  import lsu_pkg::*;

  localparam logic [3:0] OP_B  = 4'b0001;
  localparam logic [3:0] OP_H  = 4'b0010;
  localparam logic [3:0] OP_W  = 4'b0100;
  localparam logic [3:0] OP_U  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_read, req_write;
  logic [3:0]  req_opcode;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [3:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_read   = rd;
    req_write  = wr;
    req_opcode = op;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // Minimum-latency transaction; ends with resp_ready raised so the next call
  // exercises back-to-back acceptance.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    resp_ready = 1'b0;
    check_output({v.name, " req_ready"}, 32'(req_ready), 32'd1);
    issue(v.rd, v.wr, v.op, v.addr, v.wdata);
    @(negedge clk);
    req_valid = 1'b0;
    check_output({v.name, " bus_req"}, 32'(bus_req), 32'd1);
    check_output({v.name, " bus_addr"}, bus_addr, v.exp_addr);
    check_output({v.name, " bus_we"}, 32'(bus_we), 32'(v.wr));
    if (v.wr) begin
      check_output({v.name, " bus_wstrb"}, 32'(bus_wstrb), 32'(v.exp_wstrb));
      check_output({v.name, " bus_wdata"}, bus_wdata, v.exp_wdata);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    if (!v.wr) begin
      check_output({v.name, " wait no resp"}, 32'(resp_valid), 32'd0);
      check_output({v.name, " wait wstrb"}, 32'(bus_wstrb), 32'd0);
      bus_rvalid = 1'b1;
      bus_rdata  = v.rdata;
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rdata  = 32'hCAFE_F00D;
    end
    check_output({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
    check_output({v.name, " resp_rdata"}, resp_rdata, v.exp_rdata);
    check_output({v.name, " resp_err"}, 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_opcode = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    vecs[0] = '{"SW",      1'b0, 1'b1, OP_W,        32'h100, 32'hDEADBEEF, 32'h0,         32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{"SB",      1'b0, 1'b1, OP_B,        32'h103, 32'h000000A5, 32'h0,         32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[2] = '{"SH",      1'b0, 1'b1, OP_H,        32'h102, 32'h1234BEEF, 32'h0,         32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[3] = '{"SW rd+wr",1'b1, 1'b1, OP_W,        32'h108, 32'h01020304, 32'h0,         32'h108, 4'b1111, 32'h01020304, 32'h0};
    vecs[4] = '{"LH",      1'b1, 1'b0, OP_H,        32'h202, 32'h0,        32'h80011234,  32'h200, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[5] = '{"LHU",     1'b1, 1'b0, OP_H | OP_U, 32'h202, 32'h0,        32'h80011234,  32'h200, 4'b0000, 32'h0,        32'h00008001};
    vecs[6] = '{"LB",      1'b1, 1'b0, OP_B,        32'h201, 32'h0,        32'h00008000,  32'h200, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[7] = '{"LBU",     1'b1, 1'b0, OP_B | OP_U, 32'h201, 32'h0,        32'h00008000,  32'h200, 4'b0000, 32'h0,        32'h00000080};
    vecs[8] = '{"LW",      1'b1, 1'b0, OP_W,        32'h204, 32'h0,        32'h12345678,  32'h204, 4'b0000, 32'h0,        32'h12345678};
    vecs[9] = '{"LB off0", 1'b1, 1'b0, OP_B,        32'h200, 32'h0,        32'hFFFFFF7F,  32'h200, 4'b0000, 32'h0,        32'h0000007F};

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst req_ready", 32'(req_ready), 32'd0);
    check_output("rst bus_req", 32'(bus_req), 32'd0);
    check_output("rst bus_we", 32'(bus_we), 32'd0);
    check_output("rst bus_addr", bus_addr, 32'd0);
    check_output("rst bus_wstrb", 32'(bus_wstrb), 32'd0);
    check_output("rst bus_wdata", bus_wdata, 32'd0);
    check_output("rst resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst resp_rdata", resp_rdata, 32'd0);
    check_output("rst resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    check_output("post-rst req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) apply_stimulus(vecs[i]);
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("after table idle", 32'(resp_valid), 32'd0);

    // LB with grant delayed 3 cycles and response back-pressure for 2 cycles
    issue(1'b1, 1'b0, OP_B, 32'h301, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_output("LB delay bus_req", 32'(bus_req), 32'd1);
      check_output("LB delay bus_addr", bus_addr, 32'h300);
      @(negedge clk);
    end
    check_output("LB delay bus_req 4th", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    check_output("LB delay bus_req dropped", 32'(bus_req), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0000_7F00;
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      check_output("LB hold resp_valid", 32'(resp_valid), 32'd1);
      check_output("LB hold resp_rdata", resp_rdata, 32'h0000007F);
      @(negedge clk);
    end
    check_output("LB accept resp_valid", 32'(resp_valid), 32'd1);
    check_output("LB accept resp_rdata", resp_rdata, 32'h0000007F);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("LB done resp_valid", 32'(resp_valid), 32'd0);

    // Request with neither read nor write is swallowed
    issue(1'b0, 1'b0, OP_W, 32'h500, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("nop req_ready", 32'(req_ready), 32'd1);
    check_output("nop bus_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    check_output("nop resp_valid", 32'(resp_valid), 32'd0);

    // Misaligned LW at 0x102
    issue(1'b1, 1'b0, OP_W, 32'h102, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    check_output("misalign bus_req", 32'(bus_req), 32'd0);
    check_output("misalign resp_valid", 32'(resp_valid), 32'd1);
    check_output("misalign resp_err", 32'(resp_err), 32'd1);
    check_output("misalign resp_rdata", resp_rdata, 32'd0);
`else
    check_output("misalign bus_req", 32'(bus_req), 32'd1);
    check_output("misalign bus_addr", bus_addr, 32'h100);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h11223344;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check_output("misalign resp_valid", 32'(resp_valid), 32'd1);
    check_output("misalign resp_err", 32'(resp_err), 32'd0);
`endif
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during WAIT, late rvalid must be ignored
    issue(1'b1, 1'b0, OP_W, 32'h400, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst bus_req", 32'(bus_req), 32'd0);
    check_output("midrst resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h55AA55AA;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check_output("midrst late rvalid", 32'(resp_valid), 32'd0);
    check_output("midrst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check_output("midrst still idle", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32 core's memory stage. It consumes the decoder's memory controls (`mem_read`, `mem_write`, `mem_opcode`) together with the ALU-computed address and the rs2 store data. It runs one word-aligned transaction at a time on the data bus, using byte strobes. Load data is returned to writeback after alignment and sign or zero extension.

## Interface
Parameters:
- `AW`, default `` `XLEN ``: data bus address width.
- `DW`, default `` `XLEN ``: data width. Only 32 is supported.

Ports:
- `clk`  in  1  core clock. One clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  memory-stage request valid.
- `req_ready`  out  1  LSU can accept a request.
- `req_read`  in  1  load (decoder `mem_read`).
- `req_write`  in  1  store (decoder `mem_write`).
- `req_opcode`  in  `` `MEM_OP_WIDTH ``  decoder `mem_opcode`: BYTE/HALF/WORD one-hot, plus UNSIGN.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  DW  store data (rs2).
- `resp_valid`  out  1  access complete.
- `resp_ready`  in  1  writeback accepts the response.
- `resp_rdata`  out  DW  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned access (see Configuration).
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  AW  word address, with `[1:0]` = 0.
- `bus_wstrb`  out  4  byte lane enables.
- `bus_wdata`  out  DW  lane-replicated store data.
- `bus_gnt`  in  1  bus accepted the request this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  DW  read word.

## Operation
- FSM states and transitions:
  - IDLE: a request is accepted when `req_valid & req_ready & (req_read | req_write)`. The accepted request is registered and the FSM goes to REQ.
  - REQ: `bus_req` is held until `bus_gnt`. On grant, a store goes to RESP and a load goes to WAIT.
  - WAIT: the FSM waits for `bus_rvalid`, latches the extended data, and goes to RESP.
  - RESP: `resp_valid` is held until `resp_ready`, then the FSM returns to IDLE.
- `req_valid` with neither `req_read` nor `req_write` is consumed silently and produces no response.
- If both `req_read` and `req_write` are set, the request is a store.
- `req_ready` = (state == IDLE) & ~`rst`.
- Store strobes, with offset `o` = `addr[1:0]`, truncated to 4 bits:
  - BYTE: `4'b0001 << o`.
  - HALF: `4'b0011 << o`.
  - WORD: `4'b1111`.
- Store data:
  - BYTE: `{4{wdata[7:0]}}`.
  - HALF: `{2{wdata[15:0]}}`.
  - WORD: `wdata`.
- Load data:
  - Shift: `bus_rdata >> (8*o)`.
  - Extension: BYTE/HALF are sign-extended from bit 7/15. When UNSIGN is set they are zero-extended instead.
  - WORD passes through.
- `bus_we`, `bus_addr`, `bus_wstrb` and `bus_wdata` are registered at accept and stable for the whole of REQ.
- In any state other than REQ, `bus_wstrb` is 0.
- `bus_rvalid` is ignored outside WAIT. This includes `bus_rvalid` in the same cycle as `bus_gnt`; read data must arrive at least one cycle after the grant.

## Timing
- Reset values of all outputs are 0: `bus_req`, `bus_we`, `bus_addr`, `bus_wstrb`, `bus_wdata`, `resp_valid`, `resp_rdata`, `resp_err`.
- `req_ready` is 1 in the first cycle after `rst` deasserts.
- Minimum store latency (accept in cycle 0):
  - `bus_req` in cycle 1; grant in cycle 1.
  - `resp_valid` in cycle 2.
- Minimum load latency (accept in cycle 0):
  - `bus_req` in cycle 1; grant in cycle 1.
  - `bus_rvalid` in cycle 2; `resp_valid` in cycle 3.
- Back-to-back requests: after `resp_valid & resp_ready` in cycle N, the next request can be accepted in cycle N+1.
- Back-pressure: `resp_valid`, `resp_rdata` and `resp_err` are held stable while `resp_ready` = 0.
- Reset mid-operation: the FSM returns to IDLE on the next edge and `bus_req` drops. Any outstanding bus transaction is abandoned, and a late `bus_rvalid` is ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A HALF access with `addr[0]` = 1 is misaligned, as is a WORD access with `addr[1:0]` != 0.
  - A misaligned access issues no bus request and goes straight from IDLE to RESP.
  - The response has `resp_err` = 1 and `resp_rdata` = 0.
- Undefined: `resp_err` is tied to 0 and misaligned accesses proceed. Lanes past byte 3 are dropped by the truncated strobe and shift rules; no second access is made.

## Structure
- Shared package `lsu_pkg` holds:
  - the `lsu_state_t` enum (IDLE, REQ, WAIT, RESP);
  - the `MEM_OP_*` bit indices, reused from `core.svh`.
- Sub-module `lsu_align` is combinational. It takes opcode, offset and data, and produces `bus_wstrb`, `bus_wdata` and the extended load data. It is instantiated once for the store path and once for the load path.

## Test plan
- SW: addr `0x100`, data `0xDEADBEEF`, grant in the first REQ cycle -> `bus_addr` `0x100`, `bus_wstrb` `4'b1111`, `resp_valid` at cycle 2.
- SB: addr `0x103`, data `0x000000A5` -> `bus_addr` `0x100`, `bus_wstrb` `4'b1000`, `bus_wdata` `0xA5A5A5A5`.
- LH vs LHU: addr `0x202`, `bus_rdata` `0x8001_1234` -> `resp_rdata` `0xFFFF8001` for LH and `0x00008001` for LHU.
- LB with `bus_gnt` delayed 3 cycles and `resp_ready` held low for 2 cycles: addr `0x301`, rdata `0x0000_7F00` -> `bus_req` held 4 cycles; `resp_rdata` `0x0000007F`, stable until accepted.
- With `LSU_MISALIGN_CHECK_EN`, LW at `0x102` -> no `bus_req`, `resp_err` = 1 at cycle 1. Without the macro, LW at `0x102` -> bus read of `0x100` with `resp_err` = 0.
- `rst` asserted during WAIT, then `bus_rvalid` 2 cycles later -> no `resp_valid`, `req_ready` = 1 after reset.
